csoc_scan_tester: RTL and testbench
===================================

Name: csoc_scan_tester

Overview:
- Self-contained scan-chain test driver that sits directly upstream of the CSOC scan chain.
- Drives the chain's scan-enable, test-mode and serial data input (data_i[0]), and samples the chain's serial output (data_o[0]).
- Flushes the chain with zeros, shifts a 16-bit LFSR pattern through it, and compares every returned bit against a regenerated expected stream.
- Reports done, pass/fail, error count and first-mismatch index.

Parameters:
- NREGS, 1918: number of scan flops in the chain.
- CHAIN_LAT, NREGS+1: round-trip cycles from scan_di_o driven to the same bit visible on scan_do_i.
- PAT_LEN, 256: number of LFSR pattern bits shifted per run.
- CW, $clog2(PAT_LEN+CHAIN_LAT+1): width of cycle counter and first_err_o.

Ports:
- clk_i  in  1  single clock.
- rstn_i  in  1  reset, synchronous, active-low.
- start_i  in  1  start pulse; sampled only in IDLE.
- seed_i  in  16  LFSR seed, latched at start; 0 is replaced by 16'hACE1.
- busy_o  out  1  high from the cycle after start until done.
- done_o  out  1  one-cycle pulse at end of run.
- pass_o  out  1  err_cnt_o==0; valid from done_o, held until next start.
- err_cnt_o  out  16  mismatch count, saturating at 16'hFFFF.
- first_err_o  out  CW  SHIFT-cycle index of the first mismatch; all-ones if none.
- scan_tm_o  out  1  test mode, equal to busy_o.
- scan_se_o  out  1  scan enable to chain.
- scan_di_o  out  1  serial data into chain (drives data_i[0]).
- scan_do_i  in  1  serial data from chain (data_o[0]).

Behaviour:
- All outputs are registered.
- Reset (rstn_i low at posedge):
  - FSM goes to IDLE.
  - scan_se_o, scan_tm_o, scan_di_o, busy_o, done_o, pass_o are 0.
  - err_cnt_o is 0.
  - first_err_o is all-ones.
  - Applies mid-run too: the run is abandoned and no done_o is issued.
- FSM states: IDLE, FLUSH, SHIFT, DONE.
- IDLE:
  - start_i=1 latches the seed into both the generator LFSR (gen) and the checker LFSR (chk).
  - Clears err_cnt_o and resets first_err_o to all-ones.
  - Counter cnt set to 0; next state FLUSH.
  - start_i in any other state is ignored.
- FLUSH (CHAIN_LAT cycles):
  - scan_se_o=1, scan_di_o=0, no compare.
  - On cnt==CHAIN_LAT-1, go to SHIFT with cnt=0.
- SHIFT (PAT_LEN+CHAIN_LAT cycles, cycle index j=cnt):
  - scan_se_o=1.
  - scan_di_o = gen[0] for j<PAT_LEN, else 0; gen advances only for j<PAT_LEN.
  - At the clock edge ending cycle j, scan_do_i is compared against exp:
    - exp = 0 for j<CHAIN_LAT (flushed zeros);
    - exp = chk[0] otherwise, with chk advancing on each such compare.
  - On mismatch:
    - err_cnt_o increments, saturating;
    - if first_err_o is all-ones, it captures j.
  - On j==PAT_LEN+CHAIN_LAT-1, go to DONE.
- DONE (1 cycle):
  - done_o=1; scan_se_o=0, scan_tm_o=0, busy_o=0.
  - pass_o set to (final err_cnt==0); next state IDLE.
- LFSR:
  - 16-bit Fibonacci, shift right.
  - New bit[15] = b0^b2^b3^b5 (x^16+x^14+x^13+x^11+1).
  - Output bit = b0.
  - gen and chk are identical instances, so they produce identical sequences.
- Timing from a start_i sampled at edge 0:
  - busy_o high from cycle 1;
  - FLUSH occupies cycles 1..CHAIN_LAT;
  - SHIFT runs for PAT_LEN+CHAIN_LAT cycles;
  - done_o in cycle 2*CHAIN_LAT+PAT_LEN+1.
- Bit-k alignment: a bit driven in SHIFT cycle k is compared in SHIFT cycle k+CHAIN_LAT.
- Simultaneous start_i and reset: reset wins.
- Counter never wraps; CW covers the maximum index.

Test Plan:
- Healthy chain model with NREGS=8 (CHAIN_LAT=9), PAT_LEN=32, seed 16'hACE1:
  - done_o exactly in cycle 51 after start;
  - err_cnt_o=0, pass_o=1, first_err_o=all-ones;
  - scan_se_o high for cycles 1..50.
- Stuck-at-1 output model, same config:
  - first_err_o=0;
  - err_cnt_o = 9 + number of zero bits among the first 32 LFSR outputs (per reference model);
  - pass_o=0.
- Chain one flop short (actual latency 8), seed 16'h0001:
  - err_cnt_o>0 and first_err_o ≤ 9;
  - seed 0 run gives results identical to a seed 16'hACE1 run.
- Bit flip injected at pattern bit 5 only:
  - err_cnt_o=1, first_err_o=14 (5+CHAIN_LAT), pass_o=0.
- start_i pulsed again mid-SHIFT:
  - ignored; a single done_o at cycle 51.
- rstn_i low for one cycle mid-SHIFT:
  - next cycle busy_o=0, scan_se_o=0, err_cnt_o=0, no done_o;
  - a following start completes normally.

Source files
------------

// File: rtl/csoc_scan_tester.sv
// Scan-chain test driver: zero-flushes the chain, shifts an LFSR pattern through it and
// checks the returned stream against a regenerated copy, reporting pass/fail and error stats.
module csoc_scan_tester #(
   parameter int NREGS     = 1918,
   parameter int CHAIN_LAT = NREGS + 1,
   parameter int PAT_LEN   = 256,
   parameter int CW        = $clog2(PAT_LEN + CHAIN_LAT + 1)
) (
   input  logic          clk_i,
   input  logic          rstn_i,
   input  logic          start_i,
   input  logic [15:0]   seed_i,
   output logic          busy_o,
   output logic          done_o,
   output logic          pass_o,
   output logic [15:0]   err_cnt_o,
   output logic [CW-1:0] first_err_o,
   output logic          scan_tm_o,
   output logic          scan_se_o,
   output logic          scan_di_o,
   input  logic          scan_do_i
);

   typedef enum logic [1:0] {IDLE, FLUSH, SHIFT, DONE} state_t;

   localparam logic [CW-1:0] FLUSH_END = CW'(CHAIN_LAT - 1);
   localparam logic [CW-1:0] SHIFT_END = CW'(PAT_LEN + CHAIN_LAT - 1);
   localparam logic [CW-1:0] PAT_C     = CW'(PAT_LEN);
   localparam logic [CW-1:0] LAT_C     = CW'(CHAIN_LAT);

   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
   endfunction

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [15:0]   gen_q, gen_d;
   logic [15:0]   chk_q, chk_d;
   logic [15:0]   err_q, err_d;
   logic [CW-1:0] first_q, first_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          pass_q, pass_d;
   logic          se_q, se_d;
   logic          di_q, di_d;
   logic [CW-1:0] cnt_nxt;
   logic          exp_bit;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      gen_d   = gen_q;
      chk_d   = chk_q;
      err_d   = err_q;
      first_d = first_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      pass_d  = pass_q;
      se_d    = se_q;
      di_d    = di_q;
      cnt_nxt = cnt_q + 1'b1;
      exp_bit = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               gen_d   = (seed_i == 16'h0) ? 16'hACE1 : seed_i;
               chk_d   = (seed_i == 16'h0) ? 16'hACE1 : seed_i;
               err_d   = 16'h0;
               first_d = '1;
               cnt_d   = '0;
               busy_d  = 1'b1;
               se_d    = 1'b1;
               di_d    = 1'b0;
               pass_d  = 1'b0;
               state_d = FLUSH;
            end
         end
         FLUSH: begin
            cnt_d = cnt_nxt;
            if (cnt_q == FLUSH_END) begin
               cnt_d   = '0;
               di_d    = gen_q[0];
               gen_d   = lfsr_step(gen_q);
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            // The first CHAIN_LAT returned bits are the flushed zeros.
            if (cnt_q >= LAT_C) begin
               exp_bit = chk_q[0];
               chk_d   = lfsr_step(chk_q);
            end
            if (scan_do_i != exp_bit) begin
               if (err_q != 16'hFFFF) err_d = err_q + 16'h1;
               if (first_q == '1) first_d = cnt_q;
            end
            if (cnt_nxt < PAT_C) begin
               di_d  = gen_q[0];
               gen_d = lfsr_step(gen_q);
            end else begin
               di_d = 1'b0;
            end
            cnt_d = cnt_nxt;
            if (cnt_q == SHIFT_END) begin
               cnt_d   = '0;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               se_d    = 1'b0;
               di_d    = 1'b0;
               pass_d  = (err_d == 16'h0);
               state_d = DONE;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         gen_q   <= 16'h0;
         chk_q   <= 16'h0;
         err_q   <= 16'h0;
         first_q <= '1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         se_q    <= 1'b0;
         di_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         gen_q   <= gen_d;
         chk_q   <= chk_d;
         err_q   <= err_d;
         first_q <= first_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         se_q    <= se_d;
         di_q    <= di_d;
      end
   end

   assign busy_o      = busy_q;
   assign scan_tm_o   = busy_q;
   assign done_o      = done_q;
   assign pass_o      = pass_q;
   assign err_cnt_o   = err_q;
   assign first_err_o = first_q;
   assign scan_se_o   = se_q;
   assign scan_di_o   = di_q;

endmodule

// File: tb/tb_csoc_scan_tester.sv
// Bench for csoc_scan_tester: behavioural chain model with configurable latency,
// stuck-at-1 and single-cycle bit flip, checked against a stream-level reference model.
module tb_csoc_scan_tester;

   localparam int CL   = 9;
   localparam int PL   = 32;
   localparam int CW   = 6;
   localparam int NONE = 63;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          start = 1'b0;
   logic [15:0]   seed = 16'h0;
   logic          busy, done, pass, tm, se, di, sdo;
   logic [15:0]   err_cnt;
   logic [CW-1:0] first_err;

   logic [15:0] pipe = 16'h0;
   int          lat_sel = CL;
   logic        stuck = 1'b0;
   logic        flip_now = 1'b0;

   int checks = 0;
   int errors = 0;

   int r_err, r_first, r_pass, r_done_cnt, r_done_n, r_se_cnt, r_se_first, r_se_last, r_busy1;
   int m_err, m_first;

   csoc_scan_tester #(.NREGS(8), .PAT_LEN(PL)) dut (
      .clk_i(clk), .rstn_i(rstn), .start_i(start), .seed_i(seed),
      .busy_o(busy), .done_o(done), .pass_o(pass), .err_cnt_o(err_cnt),
      .first_err_o(first_err), .scan_tm_o(tm), .scan_se_o(se),
      .scan_di_o(di), .scan_do_i(sdo)
   );

   always #5 clk = ~clk;

   always @(posedge clk) pipe <= {pipe[14:0], di};
   assign sdo = stuck ? 1'b1 : (pipe[lat_sel-1] ^ flip_now);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference: build the pattern, the stream the chain returns, and the stream expected back.
   function automatic void model(input logic [15:0] sd, input int lat, input bit stk,
                                 input int flip, output int errs, output int first);
      bit pat[PL];
      logic [15:0] s;
      s = (sd == 16'h0) ? 16'hACE1 : sd;
      for (int i = 0; i < PL; i++) begin
         pat[i] = s[0];
         s = {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
      end
      errs = 0;
      first = NONE;
      for (int j = 0; j < PL + CL; j++) begin
         int k;
         bit sent, obs, expb;
         k = j - lat;
         sent = (k >= 0 && k < PL) ? pat[k] : 1'b0;
         obs = stk ? 1'b1 : (sent ^ (j == flip));
         expb = (j < CL) ? 1'b0 : pat[j-CL];
         if (obs != expb) begin
            errs++;
            if (first == NONE) first = j;
         end
      end
   endfunction

   task automatic run(input logic [15:0] sd, input int lat, input bit stk, input int flip,
                      input bit mid_start);
      lat_sel = lat;
      stuck = stk;
      @(negedge clk);
      seed = sd;
      start = 1'b1;
      r_done_cnt = 0; r_done_n = -1; r_se_cnt = 0; r_se_first = -1; r_se_last = -1;
      for (int n = 1; n <= 60; n++) begin
         @(negedge clk);
         start = (mid_start && n == 30);
         flip_now = (flip >= 0 && n == CL + 1 + flip);
         if (n == 1) r_busy1 = busy;
         if (done) begin r_done_cnt++; r_done_n = n; end
         if (se) begin
            r_se_cnt++;
            if (r_se_first < 0) r_se_first = n;
            r_se_last = n;
         end
      end
      flip_now = 1'b0;
      r_err = err_cnt;
      r_first = first_err;
      r_pass = pass;
      model(sd, lat, stk, flip, m_err, m_first);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_pass", pass, 0);
      chk("rst_se", se, 0);
      chk("rst_tm", tm, 0);
      chk("rst_di", di, 0);
      chk("rst_err", err_cnt, 0);
      chk("rst_first", first_err, NONE);
      rstn = 1'b1;

      // Healthy chain.
      run(16'hACE1, CL, 0, -1, 0);
      chk("ok_busy1", r_busy1, 1);
      chk("ok_done_n", r_done_n, 51);
      chk("ok_done_cnt", r_done_cnt, 1);
      chk("ok_err", r_err, 0);
      chk("ok_err_model", r_err, m_err);
      chk("ok_pass", r_pass, 1);
      chk("ok_first", r_first, NONE);
      chk("ok_se_cnt", r_se_cnt, 50);
      chk("ok_se_first", r_se_first, 1);
      chk("ok_se_last", r_se_last, 50);

      // Stuck-at-1 output.
      run(16'hACE1, CL, 1, -1, 0);
      chk("stuck_first", r_first, 0);
      chk("stuck_err", r_err, m_err);
      chk("stuck_pass", r_pass, 0);
      stuck = 1'b0;

      // Chain one flop short.
      run(16'h0001, CL - 1, 0, -1, 0);
      chk("short_errpos", r_err > 0, 1);
      chk("short_first_le9", r_first <= 9, 1);
      chk("short_err", r_err, m_err);
      chk("short_first", r_first, m_first);

      // Seed 0 must behave as seed ACE1.
      model(16'hACE1, CL - 1, 0, -1, m_err, m_first);
      begin
         int e_ace, f_ace;
         e_ace = m_err; f_ace = m_first;
         run(16'h0000, CL - 1, 0, -1, 0);
         chk("seed0_err", r_err, e_ace);
         chk("seed0_first", r_first, f_ace);
         run(16'hACE1, CL - 1, 0, -1, 0);
         chk("ace_err", r_err, e_ace);
         chk("ace_first", r_first, f_ace);
      end

      // Single bit flip on pattern bit 5.
      run(16'hACE1, CL, 0, 5 + CL, 0);
      chk("flip_err", r_err, 1);
      chk("flip_first", r_first, 14);
      chk("flip_pass", r_pass, 0);

      // Start during SHIFT is ignored.
      run(16'hACE1, CL, 0, -1, 1);
      chk("mid_done_cnt", r_done_cnt, 1);
      chk("mid_done_n", r_done_n, 51);
      chk("mid_err", r_err, 0);

      // Reset mid-SHIFT with a failing chain so state is dirty.
      stuck = 1'b1;
      @(negedge clk);
      seed = 16'h1234;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (28) @(negedge clk);
      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      chk("mrst_busy", busy, 0);
      chk("mrst_se", se, 0);
      chk("mrst_tm", tm, 0);
      chk("mrst_err", err_cnt, 0);
      chk("mrst_first", first_err, NONE);
      chk("mrst_done", done, 0);
      begin
         int dcnt;
         dcnt = 0;
         for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done) dcnt++;
         end
         chk("mrst_no_done", dcnt, 0);
      end
      stuck = 1'b0;
      run(16'hACE1, CL, 0, -1, 0);
      chk("after_rst_done_n", r_done_n, 51);
      chk("after_rst_pass", r_pass, 1);

      // Randomized runs.
      for (int t = 0; t < 6; t++) begin
         logic [15:0] rs;
         int rl, rf;
         rs = 16'($urandom);
         rl = $urandom_range(CL - 1, CL);
         rf = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, PL + CL - 1)) : -1;
         run(rs, rl, 0, rf, 0);
         chk("rnd_err", r_err, m_err);
         chk("rnd_first", r_first, m_first);
         chk("rnd_pass", r_pass, (m_err == 0) ? 1 : 0);
         chk("rnd_done_n", r_done_n, 51);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
